path_sequencer: RTL
===================

Name: path_sequencer

Overview:
- Supplies the path-execution block with the node triple it consumes: previous_state, node_state and next_state.
- Stores a node path written by the path planner, then steps one position along it each time the executor's nodecount changes.
- Sits between the path planner (load side) and the line-follow/turn executor (node triple out, nodecount in).
- Raises done when the final node of the path is reached.

Parameters:
- NODE_W, 5, width of a node ID.
- MAX_LEN, 32, maximum number of path entries.
- IDX_W, 5, index width; must satisfy 2^IDX_W >= MAX_LEN.
- CNT_W, 8, width of the nodecount input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  path entry present on load_node
- load_node  in  NODE_W  path entry (node ID)
- load_last  in  1  marks the final entry of the path
- load_ready  out  1  sequencer accepts an entry this cycle
- start  in  1  single-cycle pulse that begins execution of the stored path
- nodecount  in  CNT_W  executor's node-detect counter (free-running, wraps)
- previous_state  out  NODE_W  node last departed
- node_state  out  NODE_W  current node
- next_state  out  NODE_W  node to head for
- path_idx  out  IDX_W  index of node_state within the path
- running  out  1  high while in RUN
- done  out  1  high in DONE (final node reached)
- path_err  out  1  sticky flag: overflow on load, or start with path length < 2

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; stored path length is 0.
  - All outputs are 0, except load_ready = 1.
  - Path storage contents are don't-care.
- States are IDLE, LOAD, ARMED, RUN, DONE. load_ready = 1 in every state except RUN.
- Load handshake: an entry is accepted on any cycle where load_valid && load_ready.
  - First accepted entry while in IDLE, ARMED or DONE: clear length to 0, write entry 0, go to LOAD. done and path_err clear.
  - In LOAD: write entry at index = length, then increment length.
  - Entry accepted with load_last: go to ARMED on the next cycle.
  - Entry accepted with length == MAX_LEN: entry is dropped and path_err is set; state still follows load_last.
- start in ARMED or DONE:
  - Length >= 2: go to RUN. path_idx = 0; previous_state = path[0]; node_state = path[0]; next_state = path[1]. Capture nodecount into cnt_q. running = 1; done = 0.
  - Length < 2: set path_err and stay in the current state.
- start is ignored in IDLE, LOAD and RUN.
- RUN advance:
  - An advance event is any cycle where nodecount != cnt_q. cnt_q updates to nodecount on the same edge.
  - Exactly one step is taken per event, even if nodecount jumped by more than 1. Comparison is modular, so wrap 255->0 is an event.
  - Outputs update on the clock edge after nodecount changes (1-cycle latency):
    - path_idx += 1
    - previous_state = old node_state
    - node_state = path[new idx]
    - next_state = path[new idx+1]; if new idx is the last index (length-1), next_state = node_state instead.
  - If new idx == length-1: go to DONE on the same edge. running = 0; done = 1.
  - In DONE, node outputs hold their last values.
- load_valid is ignored during RUN (load_ready = 0). Outside RUN, nodecount changes are ignored.
- Simultaneous events:
  - start and a nodecount change in the same cycle: start wins, and cnt_q captures the new value.
  - start and a first load entry in ARMED/DONE in the same cycle: the load wins and start is ignored.
- Reset mid-RUN returns to IDLE and clears the path; the planner must reload.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - NODE_W and CNT_W
  - state encoding constants (IDLE=0, LOAD=1, ARMED=2, RUN=3, DONE=4)
  - a reserved NODE_NONE constant = 0
- One natural sub-module, path_store: MAX_LEN x NODE_W register array with one write port and two combinational read ports (idx, idx+1). The FSM, counters and handshake stay in path_sequencer.

Test Plan:
1. Load [0,1,29,20,24] with load_last on the 5th entry, then pulse start -> state ARMED; after start: prev=0, node=0, next=1, idx=0, running=1.
2. From test 1, step nodecount 0->1->2->3->4 with >=1 cycle between steps -> node triples (0,1,29), (1,29,20), (29,20,24), (20,24,24). done=1 and running=0 on the cycle after the 4th change.
3. Set cnt_q=255 and run a 3-entry path, nodecount 255->0 -> one advance. Jump nodecount 0->5 in a single cycle -> exactly one advance.
4. Load 33 entries with MAX_LEN=32 -> path_err=1 and length=32; start -> RUN with path[0..1] correct.
5. Load a single entry [7], then start -> path_err=1, state stays ARMED, running=0.
6. Assert rst low mid-RUN at idx=2 -> all outputs 0 and load_ready=1 asynchronously; a start issued after reset release is ignored.

Source files
------------

// File: rtl/path_sequencer_pkg.sv
// Shared constants for the path sequencer: widths, path depth, FSM encoding.
package path_sequencer_pkg;

    localparam int NODE_W  = 5;
    localparam int CNT_W   = 8;
    localparam int MAX_LEN = 32;
    localparam int IDX_W   = 5;
    localparam int LEN_W   = IDX_W + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [NODE_W-1:0] NODE_NONE = {NODE_W{1'b0}};

    // States in which the next accepted entry starts a fresh path.
    function automatic logic is_reloadable(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_ARMED) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/path_sequencer_store.sv
// Path entry storage: one write port, two combinational read ports (idx, idx+1).
module path_store
    import path_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [NODE_W-1:0] wr_node,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [NODE_W-1:0] rd_node,
    output logic [NODE_W-1:0] rd_node_nxt
);

    logic [NODE_W-1:0] mem_r [MAX_LEN];
    logic [IDX_W-1:0]  rd_idx_nxt_s;

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_node;
        end
    end

    assign rd_idx_nxt_s = rd_idx + IDX_W'(1);
    assign rd_node      = mem_r[rd_idx];
    assign rd_node_nxt  = mem_r[rd_idx_nxt_s];

endmodule

// File: rtl/path_sequencer.sv
// Stores a planner-supplied node path and steps the executor's node triple on each nodecount change.
module path_sequencer
    import path_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [NODE_W-1:0] load_node,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic [CNT_W-1:0]  nodecount,
    output logic [NODE_W-1:0] previous_state,
    output logic [NODE_W-1:0] node_state,
    output logic [NODE_W-1:0] next_state,
    output logic [IDX_W-1:0]  path_idx,
    output logic              running,
    output logic              done,
    output logic              path_err
);

    logic [2:0]        state_r, state_nxt_s;
    logic [LEN_W-1:0]  len_r;
    logic [CNT_W-1:0]  cnt_q_r;
    logic [IDX_W-1:0]  idx_r;
    logic [NODE_W-1:0] prev_r, node_r, next_r;
    logic              running_r, done_r, err_r, ready_r;

    logic              accept_s, fresh_s, start_s, len_ok_s, full_s;
    logic              advance_s, at_last_s, wr_en_s, load_more_s;
    logic [IDX_W-1:0]  idx_inc_s, wr_idx_s, rd_idx_s;
    logic [NODE_W-1:0] rd_node_s, rd_node_nxt_s;

    assign accept_s    = load_valid && ready_r;
    assign fresh_s     = accept_s && is_reloadable(state_r);
    assign load_more_s = accept_s && (state_r == ST_LOAD);
    assign full_s      = (len_r == LEN_W'(MAX_LEN));
    assign len_ok_s    = (len_r >= LEN_W'(2));
    // A load arriving with start in ARMED/DONE takes priority.
    assign start_s     = start && ((state_r == ST_ARMED) || (state_r == ST_DONE)) && !fresh_s;
    assign advance_s   = (state_r == ST_RUN) && (nodecount != cnt_q_r);
    assign idx_inc_s   = idx_r + IDX_W'(1);
    assign at_last_s   = ({1'b0, idx_inc_s} == (len_r - LEN_W'(1)));
    assign wr_en_s     = fresh_s || (load_more_s && !full_s);
    assign wr_idx_s    = fresh_s ? {IDX_W{1'b0}} : len_r[IDX_W-1:0];
    // In RUN the read pair looks ahead to the position being stepped into.
    assign rd_idx_s    = (state_r == ST_RUN) ? idx_inc_s : {IDX_W{1'b0}};

    path_store u_store (
        .clk         (clk),
        .wr_en       (wr_en_s),
        .wr_idx      (wr_idx_s),
        .wr_node     (load_node),
        .rd_idx      (rd_idx_s),
        .rd_node     (rd_node_s),
        .rd_node_nxt (rd_node_nxt_s)
    );

    // Next-state selection for the sequencer FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fresh_s) state_nxt_s = load_last ? ST_ARMED : ST_LOAD;
                else         state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (accept_s && load_last) state_nxt_s = ST_ARMED;
                else                       state_nxt_s = ST_LOAD;
            end
            ST_ARMED, ST_DONE: begin
                if (fresh_s)                    state_nxt_s = load_last ? ST_ARMED : ST_LOAD;
                else if (start_s && len_ok_s)   state_nxt_s = ST_RUN;
                else                            state_nxt_s = state_r;
            end
            ST_RUN: begin
                if (advance_s && at_last_s) state_nxt_s = ST_DONE;
                else                        state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, load handshake, stored length and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            len_r   <= {LEN_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != ST_RUN);
            if (fresh_s) begin
                len_r <= LEN_W'(1);
                err_r <= 1'b0;
            end else if (load_more_s && full_s) begin
                err_r <= 1'b1;
            end else if (load_more_s) begin
                len_r <= len_r + LEN_W'(1);
            end else if (start_s && !len_ok_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Node triple, position and run/done status presented to the executor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q_r   <= {CNT_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            prev_r    <= NODE_NONE;
            node_r    <= NODE_NONE;
            next_r    <= NODE_NONE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else if (start_s && len_ok_s) begin
            cnt_q_r   <= nodecount;
            idx_r     <= {IDX_W{1'b0}};
            prev_r    <= rd_node_s;
            node_r    <= rd_node_s;
            next_r    <= rd_node_nxt_s;
            running_r <= 1'b1;
            done_r    <= 1'b0;
        end else if (advance_s) begin
            cnt_q_r <= nodecount;
            idx_r   <= idx_inc_s;
            prev_r  <= node_r;
            node_r  <= rd_node_s;
            next_r  <= at_last_s ? rd_node_s : rd_node_nxt_s;
            if (at_last_s) begin
                running_r <= 1'b0;
                done_r    <= 1'b1;
            end
        end else if (fresh_s) begin
            done_r <= 1'b0;
        end
    end

    assign load_ready     = ready_r;
    assign previous_state = prev_r;
    assign node_state     = node_r;
    assign next_state     = next_r;
    assign path_idx       = idx_r;
    assign running        = running_r;
    assign done           = done_r;
    assign path_err       = err_r;

endmodule
